dct_frame_ctrl: RTL and testbench

Frame sequencer in front of the DCT output scaling stage. Accepts one frame configuration (DCT size) at a time, drives the scaling stage's sink side with sample-accurate `sop`/`eop` and a frame-stable `fftpts`, and passes back-pressure through. Counts the saturation events the scaling stage reports for each frame and posts a per-frame status when the frame's last scaled sample leaves the stage.

---
 rtl/dct_frame_ctrl.sv | 156 +++++++++++++++
 tb/tb_dct_frame_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_frame_ctrl.sv
// Frame sequencer in front of the DCT output scaling stage: frame config handshake,
// sop/eop sideband generation, per-frame overflow status. Optional drain watchdog: DCT_FRAME_CTRL_WDOG_EN.
module dct_frame_ctrl #(
    parameter int wCnt    = 12,
    parameter int wOvfCnt = 16,
    parameter int wWdog   = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [11:0]        cfg_fftpts,
    output logic               cfg_err,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic [11:0]        fftpts_out,
    input  logic               src_valid,
    input  logic               src_eop,
    input  logic               ovf_in,
    output logic               frame_done,
    output logic [wOvfCnt-1:0] frame_ovf_cnt,
    output logic               busy,
    output logic               frame_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [wCnt-1:0]    cnt;
    logic [wCnt-1:0]    last_idx;
    logic [wOvfCnt-1:0] ovf_run, ovf_nxt;
    logic               armed;
    logic               legal;
    logic               accept;
    logic               reject;
    logic               xfer;
    logic               is_last;
    logic               close;
    logic               ovf_hit;
    logic               wdog_expire;

    always_comb begin
        case (cfg_fftpts)
            12'd2048, 12'd1024, 12'd512, 12'd256, 12'd128, 12'd64: legal = 1'b1;
            default:                                               legal = 1'b0;
        endcase
    end

    // Full-width N-1 so that N=2048 yields 2047 rather than wrapping.
    assign last_idx = wCnt'(fftpts_out) - wCnt'(1);
    assign is_last  = (cnt == last_idx);
    assign accept   = (state == IDLE) && armed && cfg_valid && legal;
    assign reject   = (state == IDLE) && armed && cfg_valid && !legal;
    assign xfer     = (state == RUN) && in_valid && out_ready;
    assign close    = (state == DRAIN) && src_valid && src_eop;
    assign ovf_hit  = (state != IDLE) && src_valid && ovf_in;

    always_comb begin
        ovf_nxt = ovf_run;
        if (ovf_hit && (ovf_run != '1))
            ovf_nxt = ovf_run + wOvfCnt'(1);
    end

    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                cfg_ready = armed;
                if (accept)
                    state_nxt = RUN;
            end
            RUN: begin
                out_valid = in_valid;
                in_ready  = out_ready;
                out_sop   = in_valid && (cnt == '0);
                out_eop   = in_valid && is_last;
                if (xfer && is_last)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                if (close || wdog_expire)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            armed         <= 1'b0;
            cnt           <= '0;
            ovf_run       <= '0;
            fftpts_out    <= 12'd2048;
            cfg_err       <= 1'b0;
            frame_done    <= 1'b0;
            frame_ovf_cnt <= '0;
        end else begin
            state      <= state_nxt;
            armed      <= 1'b1;
            cfg_err    <= reject;
            frame_done <= close;
            if (accept) begin
                fftpts_out <= cfg_fftpts;
                cnt        <= '0;
                ovf_run    <= '0;
            end else begin
                ovf_run <= ovf_nxt;
                if (xfer)
                    cnt <= cnt + wCnt'(1);
            end
            // Report includes an overflow flagged in the closing cycle itself.
            if (close)
                frame_ovf_cnt <= ovf_nxt;
        end
    end

`ifdef DCT_FRAME_CTRL_WDOG_EN
    logic [wWdog-1:0] wdog;

    assign wdog_expire = (state == DRAIN) && !close && (wdog == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog          <= '0;
            frame_timeout <= 1'b0;
        end else begin
            frame_timeout <= wdog_expire;
            if (state != DRAIN)
                wdog <= '0;
            else
                wdog <= wdog + wWdog'(1);
        end
    end
`else
    localparam int unused_wdog_w = wWdog;

    assign wdog_expire   = 1'b0;
    assign frame_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_dct_frame_ctrl.sv
// Scoreboard bench for dct_frame_ctrl with a 1-cycle-latency scaling stage model.
// Frame records are queued on config acceptance and retired on eop transfer / frame close.
module tb_dct_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [11:0] cfg_fftpts = '0;
    logic        cfg_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop;
    logic        out_eop;
    logic [11:0] fftpts_out;
    logic        src_valid;
    logic        src_eop;
    logic        ovf_in;
    logic        frame_done;
    logic [15:0] frame_ovf_cnt;
    logic        busy;
    logic        frame_timeout;

    logic        ovf_mark = 1'b0;
    logic        withhold = 1'b0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct {
        int n;
        int ovf;
    } frame_t;

    frame_t run_q[$];
    frame_t done_q[$];
    int     ovf_idx[$];
    int     idx = 0;
    int     cyc = 0;
    int     eop_cyc = 0;

    dct_frame_ctrl #(.wCnt(12), .wOvfCnt(16), .wWdog(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_fftpts    (cfg_fftpts),
        .cfg_err       (cfg_err),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sop       (out_sop),
        .out_eop       (out_eop),
        .fftpts_out    (fftpts_out),
        .src_valid     (src_valid),
        .src_eop       (src_eop),
        .ovf_in        (ovf_in),
        .frame_done    (frame_done),
        .frame_ovf_cnt (frame_ovf_cnt),
        .busy          (busy),
        .frame_timeout (frame_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scaling stage stand-in: every accepted sample emerges one cycle later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_valid <= 1'b0;
            src_eop   <= 1'b0;
            ovf_in    <= 1'b0;
        end else begin
            src_valid <= out_valid & out_ready;
            src_eop   <= out_valid & out_ready & out_eop & ~withhold;
            ovf_in    <= out_valid & out_ready & ovf_mark;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        frame_t rec;
        if (rst_n) begin
            if (out_valid) begin
                if (run_q.size() == 0) begin
                    check("valid_without_cfg", 32'(out_valid), 0);
                end else begin
                    check("sop", 32'(out_sop), 32'(idx == 0));
                    check("eop", 32'(out_eop), 32'(idx == run_q[0].n - 1));
                    check("fftpts_run", 32'(fftpts_out), run_q[0].n);
                    check("in_ready_mirror", 32'(in_ready), 32'(out_ready));
                    if (out_ready) begin
                        if (idx == run_q[0].n - 1) begin
                            void'(run_q.pop_front());
                            idx     = 0;
                            eop_cyc = cyc;
                        end else begin
                            idx++;
                        end
                    end
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    check("spurious_done", 32'(frame_done), 0);
                end else begin
                    rec = done_q.pop_front();
                    check("ovf_cnt", 32'(frame_ovf_cnt), rec.ovf);
                    check("fftpts_at_done", 32'(fftpts_out), rec.n);
                    check("done_latency", cyc - eop_cyc, 2);
                    check("busy_at_done", 32'(busy), 0);
                    check("timeout_at_done", 32'(frame_timeout), 0);
                end
            end
`ifdef DCT_FRAME_CTRL_WDOG_EN
            if (frame_timeout) begin
                if (done_q.size() == 0) begin
                    check("spurious_timeout", 32'(frame_timeout), 0);
                end else begin
                    void'(done_q.pop_front());
                    check("wdog_latency", cyc - eop_cyc, 1025);
                    check("done_at_timeout", 32'(frame_done), 0);
                end
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int n, input bit legal, output bit done_at_accept);
        int g = 0;
        frame_t rec;
        cfg_valid  = 1'b1;
        cfg_fftpts = n[11:0];
        while (!cfg_ready && g < 5000) begin
            tick();
            g++;
        end
        done_at_accept = frame_done;
        if (!cfg_ready) begin
            check("cfg_ready_timeout", 32'(cfg_ready), 1);
        end else if (legal) begin
            rec.n   = n;
            rec.ovf = ovf_idx.size();
            run_q.push_back(rec);
            done_q.push_back(rec);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic stream(input int n, input int stall_pct, input bit hold_last);
        int sent = 0;
        int g = 0;
        int held = 0;
        in_valid = 1'b1;
        while (sent < n && g < 20000) begin
            out_ready = ($urandom_range(0, 99) >= stall_pct);
            if (hold_last && sent == n - 1 && held < 2) begin
                out_ready = 1'b0;
                held++;
            end
            ovf_mark = 1'b0;
            foreach (ovf_idx[i])
                if (ovf_idx[i] == sent) ovf_mark = 1'b1;
            @(negedge clk);
            if (in_ready) sent++;
            tick();
            g++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ovf_mark  = 1'b0;
        check("stream_xfers", sent, n);
    endtask

    task automatic wait_done(input int budget);
        int g = 0;
        while (done_q.size() > 0 && g < budget) begin
            tick();
            g++;
        end
        check("done_pending", done_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_err"},  32'(cfg_err), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_sop_eop"},  32'({out_sop, out_eop}), 0);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_done"},     32'(frame_done), 0);
        check({tag, "_timeout"},  32'(frame_timeout), 0);
        check({tag, "_busy"},     32'(busy), 0);
        check({tag, "_ovf_cnt"},  32'(frame_ovf_cnt), 0);
        check({tag, "_fftpts"},   32'(fftpts_out), 2048);
    endtask

    initial begin
        bit acc_done;

        repeat (3) tick();
        check("rst_cfg_ready", 32'(cfg_ready), 0);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        tick();
        check("idle_cfg_ready", 32'(cfg_ready), 1);
        check("idle_in_ready", 32'(in_ready), 0);

        // 64-point frame, no stalls, clean scaling.
        cfg(64, 1'b1, acc_done);
        check("busy_run", 32'(busy), 1);
        stream(64, 0, 1'b0);
        wait_done(200);

        // Illegal size rejected, then a legal one accepted.
        cfg(1000, 1'b0, acc_done);
        check("cfg_err_pulse", 32'(cfg_err), 1);
        check("cfg_err_idle", 32'(busy), 0);
        check("cfg_err_fftpts", 32'(fftpts_out), 64);
        tick();
        check("cfg_err_clear", 32'(cfg_err), 0);
        check("cfg_err_ready", 32'(cfg_ready), 1);
        cfg(128, 1'b1, acc_done);
        stream(128, 0, 1'b0);
        wait_done(200);

        // Random back-pressure with a forced stall on the last sample.
        cfg(256, 1'b1, acc_done);
        stream(256, 50, 1'b1);
        wait_done(200);

        // Seven saturating samples including the final one.
        ovf_idx = '{3, 50, 100, 200, 300, 400, 511};
        cfg(512, 1'b1, acc_done);
        stream(512, 20, 1'b0);
        wait_done(200);
        ovf_idx.delete();

        // Back-to-back frames: second config lands in the frame_done cycle.
        cfg(2048, 1'b1, acc_done);
        stream(2048, 0, 1'b0);
        cfg(1024, 1'b1, acc_done);
        check("b2b_accept_in_done", 32'(acc_done), 1);
        stream(1024, 0, 1'b0);
        wait_done(200);

        // Reset in the middle of a 2048 frame.
        cfg(2048, 1'b1, acc_done);
        stream(100, 0, 1'b0);
        rst_n = 1'b0;
        run_q.delete();
        done_q.delete();
        idx = 0;
        #1;
        check("midrst_cfg_ready", 32'(cfg_ready), 0);
        check_reset_outputs("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("midrst_no_done", 32'(frame_done), 0);
        end
        check("midrst_busy", 32'(busy), 0);
        cfg(64, 1'b1, acc_done);
        stream(64, 0, 1'b0);
        wait_done(200);

`ifdef DCT_FRAME_CTRL_WDOG_EN
        // Scaling stage never reports eop: drain watchdog must abort the frame.
        withhold = 1'b1;
        cfg(64, 1'b1, acc_done);
        stream(64, 0, 1'b0);
        wait_done(1500);
        withhold = 1'b0;
        check("wdog_idle", 32'(busy), 0);
        cfg(128, 1'b1, acc_done);
        stream(128, 0, 1'b0);
        wait_done(200);
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
